// File: rtl/up_down_counter_param.sv
// up_down_counter_param
//   Parametrised WIDTH-bit synchronous up/down counter. It has count enable,
//   parallel load, a runtime-programmable modulus (range 0..mod_max_i), and a
//   wrap or saturate mode. Outputs are a one-cycle terminal-count pulse and
//   sticky overflow/underflow flags. All outputs are registered.
//
//   Optional build macro: UDC_PRESCALE_EN
//     When defined, an internal prescaler makes the counter take one step
//     every PRESCALE_DIV enabled cycles. The port list is the same either way.
//
// Ports
//   clk_i        rising-edge clock
//   reset_n_i    synchronous reset, active-low
//   en_i         count enable
//   up_dn_i      direction, 1 = up, 0 = down
//   load_i       parallel-load strobe (higher priority than stepping)
//   load_val_i   value loaded verbatim when load_i = 1
//   mod_max_i    top of the count range, sampled every cycle
//   sat_mode_i   1 = saturate at the limits, 0 = wrap
//   clr_flags_i  clears ovf_o/unf_o (a boundary event in the same cycle wins)
//   count_o      registered count
//   tc_o         one-cycle pulse on a boundary event
//   ovf_o        sticky: an up-step hit the upper boundary
//   unf_o        sticky: a down-step hit the lower boundary
module up_down_counter_param #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned RESET_VAL    = 0,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] mod_max_i,
  input  logic             sat_mode_i,
  input  logic             clr_flags_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             unf_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             step;

`ifdef UDC_PRESCALE_EN
  localparam int unsigned PS_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            ps_hit;

  assign ps_hit = (ps_q == PS_LAST);

  // Only enabled cycles advance the prescaler. A load restarts the period.
  always_comb begin
    ps_d = ps_q;
    if (load_i) begin
      ps_d = '0;
    end else if (en_i) begin
      ps_d = ps_hit ? '0 : ps_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign step = en_i && !load_i && ps_hit;
`else
  // PRESCALE_DIV has no effect in this build.
  logic unused_prescale_div;
  assign unused_prescale_div = (PRESCALE_DIV > 1);

  assign step = en_i && !load_i;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    // Clearing happens first, so a boundary event in the same cycle still sets the flag.
    ovf_d   = ovf_q && !clr_flags_i;
    unf_d   = unf_q && !clr_flags_i;

    if (load_i) begin
      count_d = load_val_i;
    end else if (step) begin
      if (up_dn_i) begin
        // The strict compare ensures +1 only runs below mod_max, so it cannot overflow.
        // An out-of-range count going up is treated as a boundary event.
        if (count_q < mod_max_i) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = sat_mode_i ? mod_max_i : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end
      end else begin
        // Any nonzero count steps down, including values above mod_max.
        // This lets a loaded out-of-range value drain back into range.
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = sat_mode_i ? '0 : mod_max_i;
          tc_d    = 1'b1;
          unf_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= WIDTH'(RESET_VAL);
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: doc/up_down_counter_param.md
Name: up_down_counter_param

Overview:
- Parametrised successor to the team's fixed 4-bit up-counter.
- Provides a WIDTH-bit synchronous up/down counter with:
  - count enable and parallel load
  - runtime-programmable modulus
  - wrap or saturate mode
  - terminal-count pulse and sticky overflow/underflow flags
- Used as the general event/interval counter feeding FSM timeouts and rate monitors.

Parameters:
- WIDTH, 8: counter width in bits (≥2).
- RESET_VAL, 0: count value after reset; must be ≤ 2^WIDTH-1.
- PRESCALE_DIV, 4: step divider (≥2); used only when UDC_PRESCALE_EN is defined.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset_n  in  1  synchronous reset, active-low.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  parallel-load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- mod_max  in  WIDTH  top of count range (range is 0..mod_max); sampled every cycle.
- sat_mode  in  1  1 = saturate at limits, 0 = wrap.
- clr_flags  in  1  clears ovf/unf.
- count  out  WIDTH  registered count.
- tc  out  1  one-cycle registered pulse on a boundary event.
- ovf  out  1  sticky: an up-step hit the upper boundary.
- unf  out  1  sticky: a down-step hit the lower boundary.

Behaviour:
- Reset and latency:
  - All outputs are registered; single clock; no combinational input-to-output paths.
  - Reset (reset_n=0 at posedge): count=RESET_VAL, tc=0, ovf=0, unf=0. Reset overrides everything, including mid-load or mid-boundary.
  - Latency: an input change at edge N is reflected in count/tc/flags after edge N.
- Priority: reset_n > load > step (en) > hold.
- Load:
  - count <= load_val verbatim, even if load_val > mod_max.
  - tc=0; ovf/unf unchanged except by clr_flags.
- Hold (en=0, load=0): count unchanged, tc=0.
- Step (a "step" is an en=1 cycle with no load):
  - Up, count < mod_max: count+1, no event.
  - Up, count ≥ mod_max, boundary event:
    - wrap mode: count=0
    - sat mode: count=mod_max
    - both: tc=1, ovf=1
  - Down, 0 < count ≤ mod_max: count-1, no event.
  - Down, count > mod_max: count-1, no event (lets an out-of-range value drain back into range).
  - Down, count == 0, boundary event:
    - wrap mode: count=mod_max
    - sat mode: count=0
    - both: tc=1, unf=1
  - Saturated and still counting toward the limit: tc=1 and the flag re-asserts every step.
- mod_max=0: up steps are always boundary events (count stays 0, tc every step). Down from 0 also stays 0 in both modes (unf=1, tc=1).
- mod_max = 2^WIDTH-1 gives full natural range; no arithmetic overflow is permitted internally.
- Flags:
  - clr_flags=1 clears ovf and unf.
  - If a boundary event occurs in the same cycle, set wins (the flag reads 1).
- Runtime changes:
  - A direction or mod_max change takes effect on the next step with no extra state.
  - A sat_mode change takes effect on the next step.

Optional Feature:
- Macro UDC_PRESCALE_EN.
- Defined:
  - An internal prescaler (width ceil(log2(PRESCALE_DIV))) advances only on en=1 cycles.
  - A counter step occurs only when en=1 and the prescaler == PRESCALE_DIV-1; the prescaler then returns to 0.
  - The prescaler clears on reset and on load.
  - en=0 freezes the prescaler.
  - tc and flags are evaluated only on real steps.
- Not defined: every en=1 cycle is a step; PRESCALE_DIV is ignored; no prescaler logic is synthesised.
- Port list is identical in both builds.

Test Plan:
1. Reset, then 260 cycles with WIDTH=8, en=1, up_dn=1, mod_max=255, sat_mode=0:
   - count runs 0..255 then 0.
   - tc high exactly on the cycle count shows 0 after 255.
   - ovf=1 after the wrap, unf=0.
2. Load 9, mod_max=9, sat_mode=1, up 3 steps → count holds 9, tc=1 on each step, ovf=1; then clr_flags=1 with en=0 → ovf=0 next cycle.
3. Load 2, mod_max=5, sat_mode=0, down 4 steps → count 1, 0, 5, 4; tc/unf assert only with the 0→5 transition.
4. Simultaneous events:
   - load=1, en=1, load_val=200, mod_max=50 → count=200, tc=0.
   - Next up step → wrap mode: count=0, tc=1, ovf=1.
   - Repeat from load 200 with down steps → 199, 198.
   - clr_flags=1 in the same cycle as a boundary event → flag reads 1.
5. Reset mid-operation: reset_n=0 while count=37 and ovf=1, with load=1 → count=RESET_VAL, tc=0, ovf=0, unf=0 after the edge; counting resumes from RESET_VAL on release.
6. UDC_PRESCALE_EN build, PRESCALE_DIV=4:
   - 12 en cycles → count advances 0→3, one step every 4th en cycle.
   - en gaps do not advance the prescaler.
   - A load mid-period restarts the 4-cycle spacing.
